relu_channel_scheduler: RTL and testbench

//  Sequences a D-channel W x H feature map through one shared LANES-wide ReLU

---
 rtl/relu_sched_pkg.sv | 21 ++
 rtl/relu_lane_array.sv | 33 +++
 rtl/relu_channel_scheduler.sv | 165 ++++++++++++++++
 tb/tb_relu_channel_scheduler.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/relu_sched_pkg.sv
// ============================================================================
// relu_sched_pkg : shared types and constants for the ReLU channel scheduler
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package relu_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Leaky slope is 1/8, implemented as an arithmetic right shift.
    localparam int LEAKY_SHIFT = 3;

endpackage

`default_nettype wire

// File: rtl/relu_lane_array.sv
// ============================================================================
// relu_lane_array : combinational LANES-wide rectifier (LEAKY_RELU_EN selects leaky)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module relu_lane_array
    import relu_sched_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    output logic [LANES*DATA_WIDTH-1:0] out_data
);

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            logic [DATA_WIDTH-1:0] w_x;
            assign w_x = in_data[i*DATA_WIDTH +: DATA_WIDTH];
`ifdef LEAKY_RELU_EN
            assign out_data[i*DATA_WIDTH +: DATA_WIDTH] =
                w_x[DATA_WIDTH-1] ? DATA_WIDTH'($signed(w_x) >>> LEAKY_SHIFT) : w_x;
`else
            assign out_data[i*DATA_WIDTH +: DATA_WIDTH] =
                w_x[DATA_WIDTH-1] ? '0 : w_x;
`endif
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/relu_channel_scheduler.sv
// ============================================================================
// relu_channel_scheduler : streams a D-channel feature map through a shared
// ReLU lane array with a 2-entry result FIFO. Optional macro: LEAKY_RELU_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module relu_channel_scheduler
    import relu_sched_pkg::*;
#(
    parameter  int W          = 28,
    parameter  int H          = 28,
    parameter  int D          = 6,
    parameter  int DATA_WIDTH = 16,
    parameter  int LANES      = 4,
    localparam int WPC        = W*H/LANES,
    localparam int NW         = WPC*D,
    localparam int AW         = $clog2(NW),
    localparam int CW         = $clog2(D),
    localparam int DWW        = LANES*DATA_WIDTH
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           rd_en,
    output logic [AW-1:0]  rd_addr,
    input  logic [DWW-1:0] rd_data,
    output logic           wr_en,
    output logic [AW-1:0]  wr_addr,
    output logic [DWW-1:0] wr_data,
    input  logic           wr_ready,
    output logic [CW-1:0]  ch_idx,
    output logic           ch_done
);

    localparam int             WCW         = (WPC > 1) ? $clog2(WPC) : 1;
    localparam logic [AW-1:0]  C_LAST_ADDR = AW'(NW - 1);
    localparam logic [WCW-1:0] C_LAST_WORD = WCW'(WPC - 1);
    localparam logic [CW-1:0]  C_LAST_CH   = CW'(D - 1);

    generate
        if ((W*H) % LANES != 0) begin : g_bad_lanes
            $error("relu_channel_scheduler: W*H must be a multiple of LANES");
        end
    endgenerate

    state_t         r_state, w_state_nxt;
    logic [AW-1:0]  r_rd_addr, r_pend_addr;
    logic           r_rd_pend;
    logic [AW-1:0]  r_fifo_addr [2];
    logic [DWW-1:0] r_fifo_data [2];
    logic           r_head, r_tail;
    logic [1:0]     r_count;
    logic [WCW-1:0] r_ch_word;
    logic [CW-1:0]  r_ch_idx;
    logic           r_ch_done;
    logic [DWW-1:0] w_rect;
    logic           w_start_ok, w_pop, w_push, w_rd_fire;
    logic [2:0]     w_occ;

    relu_lane_array #(
        .LANES      (LANES),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lanes (
        .in_data  (rd_data),
        .out_data (w_rect)
    );

    assign w_start_ok = (r_state == IDLE) && start;
    assign w_pop      = (r_count != 2'd0) && wr_ready;
    assign w_push     = r_rd_pend;
    // Credit counts both queued words and the read whose data lands next cycle.
    assign w_occ      = 3'(r_count) + 3'(r_rd_pend) - 3'(w_pop);
    assign w_rd_fire  = (r_state == RUN) && (w_occ < 3'd2);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_rd_fire && (r_rd_addr == C_LAST_ADDR)) w_state_nxt = DRAIN;
            DRAIN:   if (!r_rd_pend && ((r_count - 2'(w_pop)) == 2'd0)) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_addr   <= '0;
            r_pend_addr <= '0;
            r_rd_pend   <= 1'b0;
        end else begin
            r_rd_pend <= w_rd_fire;
            if (w_start_ok) begin
                r_rd_addr <= '0;
            end else if (w_rd_fire) begin
                r_pend_addr <= r_rd_addr;
                if (r_rd_addr != C_LAST_ADDR) r_rd_addr <= r_rd_addr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fifo_addr[0] <= '0;
            r_fifo_addr[1] <= '0;
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_head         <= 1'b0;
            r_tail         <= 1'b0;
            r_count        <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_addr[r_tail] <= r_pend_addr;
                r_fifo_data[r_tail] <= w_rect;
                r_tail              <= ~r_tail;
            end
            if (w_pop) r_head <= ~r_head;
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

    // Channel tracking by word counter avoids dividing wr_addr by WPC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ch_word <= '0;
            r_ch_idx  <= '0;
            r_ch_done <= 1'b0;
        end else begin
            r_ch_done <= 1'b0;
            if (w_start_ok) begin
                r_ch_word <= '0;
                r_ch_idx  <= '0;
            end else if (w_pop) begin
                if (r_ch_word == C_LAST_WORD) begin
                    r_ch_word <= '0;
                    r_ch_done <= 1'b1;
                    r_ch_idx  <= (r_ch_idx == C_LAST_CH) ? '0 : r_ch_idx + CW'(1);
                end else begin
                    r_ch_word <= r_ch_word + WCW'(1);
                end
            end
        end
    end

    assign busy    = (r_state == RUN) || (r_state == DRAIN);
    assign done    = (r_state == DONE);
    assign rd_en   = w_rd_fire;
    assign rd_addr = r_rd_addr;
    assign wr_en   = (r_count != 2'd0);
    assign wr_addr = r_fifo_addr[r_head];
    assign wr_data = r_fifo_data[r_head];
    assign ch_idx  = r_ch_idx;
    assign ch_done = r_ch_done;

endmodule

`default_nettype wire

// File: tb/tb_relu_channel_scheduler.sv
// ============================================================================
// tb_relu_channel_scheduler : self-checking bench, small (4x4x2) and default DUTs
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_relu_channel_scheduler;

    localparam int S_NW  = 8;
    localparam int S_WPC = 4;
    localparam int B_NW  = 1176;
    localparam int B_WPC = 196;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // small instance signals
    logic        s_start = 1'b0, s_busy, s_done, s_rd_en, s_wr_en, s_ch_done;
    logic        s_wr_ready = 1'b1;
    logic [2:0]  s_rd_addr, s_wr_addr;
    logic [0:0]  s_ch_idx;
    logic [63:0] s_rd_data = '0, s_wr_data;
    logic [63:0] s_mem [S_NW];

    // default-parameter instance signals
    logic        b_start = 1'b0, b_busy, b_done, b_rd_en, b_wr_en, b_ch_done;
    logic        b_wr_ready = 1'b1;
    logic [10:0] b_rd_addr, b_wr_addr;
    logic [2:0]  b_ch_idx;
    logic [63:0] b_rd_data = '0, b_wr_data;
    logic [63:0] b_mem [B_NW];

    relu_channel_scheduler #(.W(4), .H(4), .D(2), .DATA_WIDTH(16), .LANES(4)) u_small (
        .clk(clk), .reset(reset), .start(s_start), .busy(s_busy), .done(s_done),
        .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .wr_ready(s_wr_ready),
        .ch_idx(s_ch_idx), .ch_done(s_ch_done)
    );

    relu_channel_scheduler u_big (
        .clk(clk), .reset(reset), .start(b_start), .busy(b_busy), .done(b_done),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_ready(b_wr_ready),
        .ch_idx(b_ch_idx), .ch_done(b_ch_done)
    );

    // input buffers: one-cycle read latency
    always @(posedge clk) if (s_rd_en) s_rd_data <= s_mem[s_rd_addr];
    always @(posedge clk) if (b_rd_en) b_rd_data <= b_mem[b_rd_addr];

    // observation logs
    int          s_wq_addr[$], s_wq_ch[$], s_wq_cyc[$], s_done_cyc[$], s_chd_cyc[$], s_rq[$];
    logic [63:0] s_wq_data[$];
    int          s_unstable = 0;
    logic        s_hold = 1'b0;
    logic [2:0]  s_prev_a;
    logic [63:0] s_prev_d;

    int          b_wq_addr[$], b_wq_ch[$], b_wq_cyc[$], b_done_cyc[$], b_chd_cyc[$];
    logic [63:0] b_wq_data[$];
    int          b_unstable = 0;
    logic        b_hold = 1'b0;
    logic [10:0] b_prev_a;
    logic [63:0] b_prev_d;

    always @(negedge clk) begin
        if (s_wr_en && s_wr_ready) begin
            s_wq_addr.push_back(int'(s_wr_addr));
            s_wq_data.push_back(s_wr_data);
            s_wq_ch.push_back(int'(s_ch_idx));
            s_wq_cyc.push_back(cyc);
        end
        if (s_done) s_done_cyc.push_back(cyc);
        if (s_ch_done) s_chd_cyc.push_back(cyc);
        if (s_rd_en) s_rq.push_back(int'(s_rd_addr));
        if (s_hold && (!s_wr_en || s_wr_addr !== s_prev_a || s_wr_data !== s_prev_d))
            s_unstable++;
        s_hold   = s_wr_en && !s_wr_ready;
        s_prev_a = s_wr_addr;
        s_prev_d = s_wr_data;
    end

    always @(negedge clk) begin
        if (b_wr_en && b_wr_ready) begin
            b_wq_addr.push_back(int'(b_wr_addr));
            b_wq_data.push_back(b_wr_data);
            b_wq_ch.push_back(int'(b_ch_idx));
            b_wq_cyc.push_back(cyc);
        end
        if (b_done) b_done_cyc.push_back(cyc);
        if (b_ch_done) b_chd_cyc.push_back(cyc);
        if (b_hold && (!b_wr_en || b_wr_addr !== b_prev_a || b_wr_data !== b_prev_d))
            b_unstable++;
        b_hold   = b_wr_en && !b_wr_ready;
        b_prev_a = b_wr_addr;
        b_prev_d = b_wr_data;
    end

    // reference rectifier: per-lane signed arithmetic
    function automatic logic [63:0] relu_word(input logic [63:0] x);
        logic [63:0] r;
        logic [15:0] lane;
        int v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            lane = x[i*16 +: 16];
            v = int'($signed(lane));
            if (v < 0) begin
`ifdef LEAKY_RELU_EN
                v = (v - 7) / 8;
`else
                v = 0;
`endif
            end
            r[i*16 +: 16] = 16'(v);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_s();
        s_wq_addr.delete(); s_wq_data.delete(); s_wq_ch.delete(); s_wq_cyc.delete();
        s_done_cyc.delete(); s_chd_cyc.delete(); s_rq.delete();
        s_unstable = 0;
    endtask

    task automatic start_s(output int c0);
        tick();
        s_start = 1'b1;
        c0 = cyc;
        tick();
        s_start = 1'b0;
    endtask

    task automatic wait_done_s(input int budget);
        int n;
        n = 0;
        while (s_done_cyc.size() == 0 && n < budget) begin
            tick();
            n++;
        end
        tick();
        tick();
    endtask

    // ordered scoreboard for one small pass
    task automatic score_s(input string tag);
        int bad;
        bad = 0;
        checks++;
        if (s_wq_addr.size() != S_NW) begin
            failures++;
            $display("FAIL %s_write_count: got %0d expected %0d", tag, s_wq_addr.size(), S_NW);
        end
        for (int i = 0; i < s_wq_addr.size(); i++) begin
            checks++;
            if (s_wq_addr[i] != i || s_wq_data[i] !== relu_word(s_mem[i]) || s_wq_ch[i] != i / S_WPC) begin
                failures++;
                $display("FAIL %s_write[%0d]: got addr=%0d data=%h ch=%0d expected addr=%0d data=%h ch=%0d",
                         tag, i, s_wq_addr[i], s_wq_data[i], s_wq_ch[i], i,
                         relu_word(s_mem[i < S_NW ? i : 0]), i / S_WPC);
                bad++;
            end
        end
        checks++;
        if (s_done_cyc.size() != 1) begin
            failures++;
            $display("FAIL %s_done_count: got %0d expected 1", tag, s_done_cyc.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if ({s_busy, s_done, s_rd_en, s_wr_en, s_ch_done} !== 5'b0) begin
            failures++;
            $display("FAIL reset_small_ctrl: got %b expected 00000",
                     {s_busy, s_done, s_rd_en, s_wr_en, s_ch_done});
        end
        checks++;
        if (s_rd_addr !== 3'd0 || s_wr_addr !== 3'd0 || s_wr_data !== 64'd0 || s_ch_idx !== 1'b0) begin
            failures++;
            $display("FAIL reset_small_data: got rd=%h wr=%h data=%h ch=%h expected zeros",
                     s_rd_addr, s_wr_addr, s_wr_data, s_ch_idx);
        end
        checks++;
        if ({b_busy, b_done, b_rd_en, b_wr_en, b_ch_done} !== 5'b0 || b_wr_data !== 64'd0 ||
            b_rd_addr !== 11'd0 || b_wr_addr !== 11'd0 || b_ch_idx !== 3'd0) begin
            failures++;
            $display("FAIL reset_big: got ctrl=%b data=%h expected zeros",
                     {b_busy, b_done, b_rd_en, b_wr_en, b_ch_done}, b_wr_data);
        end
        #2;
        reset = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_basic();
        int c0;
        for (int a = 0; a < S_NW; a++)
            for (int i = 0; i < 4; i++)
                s_mem[a][i*16 +: 16] = 16'(a*16 + i*3 + 1);
        s_wr_ready = 1'b1;
        clear_s();
        start_s(c0);
        wait_done_s(50);
        score_s("basic");
        for (int i = 0; i < s_wq_cyc.size(); i++) begin
            checks++;
            if (s_wq_cyc[i] != c0 + 3 + i) begin
                failures++;
                $display("FAIL basic_write_cycle[%0d]: got %0d expected %0d", i, s_wq_cyc[i] - c0, 3 + i);
            end
        end
        checks++;
        if (s_done_cyc.size() == 0 || s_done_cyc[0] != c0 + S_NW + 3) begin
            failures++;
            $display("FAIL basic_done_latency: got %0d expected %0d",
                     s_done_cyc.size() == 0 ? -1 : s_done_cyc[0] - c0, S_NW + 3);
        end
        checks++;
        if (s_chd_cyc.size() != 2 || s_chd_cyc[0] != c0 + 7 || s_chd_cyc[1] != c0 + 11) begin
            failures++;
            $display("FAIL basic_ch_done: got n=%0d first=%0d expected n=2 at 7,11",
                     s_chd_cyc.size(), s_chd_cyc.size() == 0 ? -1 : s_chd_cyc[0] - c0);
        end
        checks++;
        if (s_rq.size() != S_NW || s_rq[0] != 0) begin
            failures++;
            $display("FAIL basic_reads: got n=%0d expected %0d", s_rq.size(), S_NW);
        end
    endtask

    task automatic test_lanes();
        int c0;
        logic [15:0] exp_l [4];
        logic [63:0] w;
        s_mem[0] = 64'h7FFF_0000_FFFF_8000;
        for (int a = 1; a < S_NW; a++) s_mem[a] = {$urandom, $urandom};
`ifdef LEAKY_RELU_EN
        exp_l[0] = 16'hF000; exp_l[1] = 16'hFFFF; exp_l[2] = 16'h0000; exp_l[3] = 16'h7FFF;
`else
        exp_l[0] = 16'h0000; exp_l[1] = 16'h0000; exp_l[2] = 16'h0000; exp_l[3] = 16'h7FFF;
`endif
        clear_s();
        start_s(c0);
        wait_done_s(50);
        w = (s_wq_data.size() > 0) ? s_wq_data[0] : 64'hDEAD_DEAD_DEAD_DEAD;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (w[i*16 +: 16] !== exp_l[i]) begin
                failures++;
                $display("FAIL lane_value[%0d]: got %h expected %h", i, w[i*16 +: 16], exp_l[i]);
            end
        end
        score_s("lanes");
    endtask

    task automatic test_backpressure();
        int c0;
        for (int a = 0; a < S_NW; a++) s_mem[a] = {$urandom, $urandom};
        clear_s();
        start_s(c0);
        for (int k = 0; k < 40 && s_done_cyc.size() == 0; k++) begin
            s_wr_ready = !(cyc >= c0 + 5 && cyc <= c0 + 9);
            @(negedge clk);
            if (cyc >= c0 + 7 && cyc <= c0 + 9) begin
                checks++;
                if (s_rd_en !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_rd_en at %0d: got %b expected 0", cyc - c0, s_rd_en);
                end
            end
            tick();
        end
        s_wr_ready = 1'b1;
        tick(); tick();
        score_s("stall");
        checks++;
        if (s_unstable != 0) begin
            failures++;
            $display("FAIL stall_stability: got %0d changes expected 0", s_unstable);
        end
    endtask

    task automatic test_start_ignored();
        int c0;
        for (int a = 0; a < S_NW; a++) s_mem[a] = {$urandom, $urandom};
        clear_s();
        start_s(c0);
        for (int k = 2; k <= 20; k++) begin
            tick();
            s_start = (cyc == c0 + 4) || (cyc == c0 + 11);
        end
        s_start = 1'b0;
        tick();
        score_s("restart_first");
        checks++;
        if (s_rq.size() != S_NW || s_busy !== 1'b0) begin
            failures++;
            $display("FAIL restart_ignored: got reads=%0d busy=%b expected %0d reads busy=0",
                     s_rq.size(), s_busy, S_NW);
        end
        clear_s();
        start_s(c0);
        wait_done_s(50);
        score_s("restart_second");
    endtask

    task automatic test_reset_midpass();
        int c0, n;
        for (int a = 0; a < S_NW; a++) s_mem[a] = {$urandom, $urandom};
        clear_s();
        start_s(c0);
        n = 0;
        @(negedge clk);
        while (!(s_rd_en && s_rd_addr == 3'd3) && n < 20) begin
            @(negedge clk);
            n++;
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({s_busy, s_done, s_rd_en, s_wr_en, s_ch_done} !== 5'b0 || s_rd_addr !== 3'd0 ||
            s_wr_addr !== 3'd0 || s_wr_data !== 64'd0 || s_ch_idx !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs: got ctrl=%b rd=%h wr=%h data=%h expected zeros",
                     {s_busy, s_done, s_rd_en, s_wr_en, s_ch_done}, s_rd_addr, s_wr_addr, s_wr_data);
        end
        tick(); tick();
        reset = 1'b1;
        clear_s();
        repeat (6) tick();
        checks++;
        if (s_rq.size() != 0 || s_wq_addr.size() != 0 || s_busy !== 1'b0 || s_done_cyc.size() != 0) begin
            failures++;
            $display("FAIL midreset_quiet: got reads=%0d writes=%0d busy=%b expected none",
                     s_rq.size(), s_wq_addr.size(), s_busy);
        end
        start_s(c0);
        wait_done_s(50);
        checks++;
        if (s_rq.size() == 0 || s_rq[0] != 0) begin
            failures++;
            $display("FAIL midreset_first_addr: got %0d expected 0", s_rq.size() == 0 ? -1 : s_rq[0]);
        end
        score_s("midreset_pass");
    endtask

    task automatic test_random_big();
        int n, bad, chd_bad, max_ch;
        for (int a = 0; a < B_NW; a++) b_mem[a] = {$urandom, $urandom};
        tick();
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        n = 0;
        while (b_done_cyc.size() == 0 && n < 8000) begin
            b_wr_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        b_wr_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (b_wq_addr.size() != B_NW) begin
            failures++;
            $display("FAIL big_write_count: got %0d expected %0d", b_wq_addr.size(), B_NW);
        end
        bad = 0;
        max_ch = 0;
        for (int i = 0; i < b_wq_addr.size(); i++) begin
            if (b_wq_addr[i] != i || b_wq_data[i] !== relu_word(b_mem[i < B_NW ? i : 0]) ||
                b_wq_ch[i] != i / B_WPC) bad++;
            if (b_wq_ch[i] > max_ch) max_ch = b_wq_ch[i];
        end
        checks++;
        if (bad != 0 || max_ch != 5) begin
            failures++;
            $display("FAIL big_scoreboard: got %0d bad words max_ch=%0d expected 0 bad max_ch=5", bad, max_ch);
        end
        chd_bad = 0;
        for (int k = 0; k < b_chd_cyc.size(); k++)
            if ((k+1)*B_WPC - 1 >= b_wq_cyc.size() || b_chd_cyc[k] != b_wq_cyc[(k+1)*B_WPC - 1] + 1)
                chd_bad++;
        checks++;
        if (b_chd_cyc.size() != 6 || chd_bad != 0) begin
            failures++;
            $display("FAIL big_ch_done: got n=%0d mistimed=%0d expected n=6 mistimed=0",
                     b_chd_cyc.size(), chd_bad);
        end
        checks++;
        if (b_done_cyc.size() != 1 || b_chd_cyc.size() == 0 || b_chd_cyc[b_chd_cyc.size()-1] != b_done_cyc[0]) begin
            failures++;
            $display("FAIL big_done: got n=%0d expected 1 coincident with last ch_done", b_done_cyc.size());
        end
        checks++;
        if (b_unstable != 0) begin
            failures++;
            $display("FAIL big_stability: got %0d changes expected 0", b_unstable);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_lanes();
        test_backpressure();
        test_start_ignored();
        test_reset_midpass();
        test_random_big();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
